instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- IF stage of the 5-stage RISC-V pipeline, directly upstream of instruction decode.
- Owns the PC and fetches from instruction memory over a request/grant/response interface with one request outstanding.
- Owns the IF/ID pipeline register: instruction plus NPC (fetch PC + 4), which feeds decode.
- Handles hazard stalls from decode and PC redirects (branch/jump) from later stages.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction word inserted on a bubble or flush (addi x0,x0,0).

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- stall  in  1  hazard stall from decode: hold PC and IF/ID.
- pc_src  in  1  redirect request: branch/jump taken.
- branch_target  in  32  redirect PC.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address (current PC).
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid.
- imem_rdata  in  32  instruction word; meaningful only when imem_rvalid = 1.
- if_id_instruction_out  out  32  IF/ID instruction.
- if_id_npc_out  out  32  IF/ID next PC (fetch PC + 4).
- if_id_valid  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (reset = 0, asynchronous):
  - pc = RESET_PC; state = REQ; hold buffer empty.
  - if_id_instruction_out = NOP_INSTR, if_id_npc_out = 0, if_id_valid = 0.
  - imem_req is forced to 0 while reset = 0.
- Memory protocol:
  - imem_req is high only in state REQ, with imem_addr = pc.
  - A request is accepted when imem_req & imem_gnt.
  - imem_rvalid arrives at least 1 cycle after the grant, exactly once per granted request.
  - imem_rvalid outside WAIT/DROP is ignored.
- States:
  - REQ: assert request. On gnt, go to WAIT.
  - WAIT: on rvalid:
    - stall = 0: load IF/ID with {imem_rdata, pc+4, valid 1}, set pc <= pc+4, go to REQ.
    - stall = 1: capture imem_rdata into the hold buffer, go to HOLD.
  - HOLD: when stall = 0, load IF/ID from the hold buffer {buf, pc+4, 1}, set pc <= pc+4, go to REQ.
  - DROP: a response is owed for a request that has been redirected away. On rvalid, discard the data and go to REQ.
- IF/ID update rule:
  - stall = 1: IF/ID holds its value.
  - stall = 0 with no instruction delivered that cycle: load bubble {NOP_INSTR, 0, 0}.
  - The combinational path from imem_rdata to IF/ID is allowed. Minimum fetch-to-IF/ID latency is 2 cycles after the request is asserted with gnt = 1 in the first cycle.
- Redirect (pc_src = 1) has highest priority and overrides stall:
  - pc <= {branch_target[31:2], 2'b00}.
  - IF/ID <= bubble; hold buffer cleared.
  - Next state:
    - REQ without gnt: REQ.
    - REQ with gnt same cycle: DROP.
    - WAIT without rvalid: DROP.
    - WAIT with rvalid same cycle: data discarded, REQ.
    - HOLD: REQ.
    - DROP without rvalid: DROP (pc updated).
    - DROP with rvalid same cycle: REQ.
- PC arithmetic:
  - 32-bit, wraps modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
  - pc[1:0] is always 0.
- Stall with the PC idle in REQ: requests continue to be issued. Fetched data waits in HOLD. No more than one instruction is buffered.
- Reset asserted mid-WAIT: a late rvalid after reset release is ignored because state = REQ. The memory model is reset together with this block.

Decomposition:
- Shared package:
  - Fetch state enum {REQ, WAIT, HOLD, DROP}.
  - NOP_INSTR constant.
  - Default RESET_PC.
  - XLEN = 32.
- One sub-module: if_id_reg, the IF/ID pipeline register with load, hold and bubble controls, and async active-low reset. The FSM and PC stay in instruction_fetch.

Test Plan:
- Reset then free-run, 1-cycle memory, gnt always 1, mem[0]=32'h00500093, mem[4]=32'h00A00113 -> imem_addr 0,4,8…; IF/ID shows {00500093, npc 4, valid 1} then {00A00113, npc 8, valid 1}; a bubble (valid 0, NOP) appears between fetches.
- stall=1 for 3 cycles while a response arrives for pc=8 -> IF/ID frozen, state HOLD, no new imem_req; on stall release IF/ID = {mem[8], 12, 1} and the next request goes to 12.
- pc_src=1, branch_target=32'h0000_0102 while in WAIT for pc=16 -> next rvalid discarded; next imem_addr = 32'h100; IF/ID bubble the cycle after redirect; IF/ID next loads {mem[100], 104, 1}.
- Redirect and stall in the same cycle while HOLD holds data -> buffer discarded, IF/ID = bubble, pc = target.
- RESET_PC=32'hFFFF_FFFC -> first fetch at FFFF_FFFC with npc 0; next imem_addr = 0.
- Assert reset mid-WAIT, release, then pulse a stale rvalid -> IF/ID stays {NOP_INSTR, 0, 0}; imem_addr = RESET_PC with imem_req=1.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// ---------------------------------------------------------------------------
// instruction_fetch_pkg
// Shared definitions for the IF stage of the 5-stage RISC-V pipeline:
//   XLEN             - datapath width (32)
//   NOP_INSTR        - addi x0,x0,0, used for IF/ID bubbles and flushes
//   DEFAULT_RESET_PC - PC loaded on reset unless overridden
//   fetch_state_t    - fetch FSM states (request, wait, hold, drop)
//   align_pc()       - clears the two low bits of a redirect address
// ---------------------------------------------------------------------------
package instruction_fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_HOLD = 2'd2,
        FETCH_DROP = 2'd3
    } fetch_state_t;

    // Instructions are word aligned, so a redirect target never carries
    // meaningful low bits into the PC.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register holding the fetched instruction and its NPC.
// Ports:
//   clock, reset   - rising-edge clock, asynchronous active-low reset
//   load           - capture {instr_in, npc_in} and mark the entry valid
//   bubble         - replace the contents with {BUBBLE_INSTR, 0, invalid}
//   instr_in       - instruction word to capture
//   npc_in         - address of the following instruction (fetch PC + 4)
//   instruction    - registered instruction
//   npc            - registered next PC
//   valid          - registered entry holds a real instruction
// With neither load nor bubble the register holds its value (stall).
// ---------------------------------------------------------------------------
module if_id_reg
    import instruction_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] BUBBLE_INSTR = NOP_INSTR
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            load,
    input  logic            bubble,
    input  logic [XLEN-1:0] instr_in,
    input  logic [XLEN-1:0] npc_in,
    output logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] npc,
    output logic            valid
);

    // Bubble wins over load so that a flush can never let an instruction
    // slip into decode in the same cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            instruction <= BUBBLE_INSTR;
            npc         <= '0;
            valid       <= 1'b0;
        end else if (bubble) begin
            instruction <= BUBBLE_INSTR;
            npc         <= '0;
            valid       <= 1'b0;
        end else if (load) begin
            instruction <= instr_in;
            npc         <= npc_in;
            valid       <= 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
// IF stage: owns the PC, fetches from instruction memory over a
// request/grant/response interface with one request outstanding, and owns
// the IF/ID register that feeds decode.
// Ports:
//   clock                 - rising-edge clock
//   reset                 - asynchronous active-low reset
//   stall                 - decode hazard: hold PC and IF/ID
//   pc_src, branch_target - redirect request and its target PC
//   imem_req, imem_addr   - fetch request and address (current PC)
//   imem_gnt              - request accepted this cycle
//   imem_rvalid           - response valid
//   imem_rdata            - instruction word (meaningful with imem_rvalid)
//   if_id_instruction_out - IF/ID instruction
//   if_id_npc_out         - IF/ID next PC (fetch PC + 4)
//   if_id_valid           - IF/ID holds a real instruction
// ---------------------------------------------------------------------------
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = instruction_fetch_pkg::DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = instruction_fetch_pkg::NOP_INSTR
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        pc_src,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instruction_out,
    output logic [31:0] if_id_npc_out,
    output logic        if_id_valid
);

    import instruction_fetch_pkg::*;

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] hold_buf;
    logic [XLEN-1:0] deliver_instr;
    logic            deliver;
    logic            if_id_load;
    logic            if_id_bubble;

    // The request is a decode of the state register; gating with reset keeps
    // the bus quiet for the whole time the block is held in reset.
    assign imem_req  = reset && (state == FETCH_REQ);
    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;

    // An instruction is available to decode either straight from memory
    // (response in WAIT) or from the hold buffer after a stall.
    always_comb begin
        deliver       = 1'b0;
        deliver_instr = hold_buf;
        if (state == FETCH_WAIT && imem_rvalid) begin
            deliver       = 1'b1;
            deliver_instr = imem_rdata;
        end else if (state == FETCH_HOLD) begin
            deliver = 1'b1;
        end
    end

    // Redirect flushes regardless of stall; otherwise a non-stalled cycle
    // either loads the delivered instruction or inserts a bubble.
    assign if_id_load   = !pc_src && !stall && deliver;
    assign if_id_bubble = pc_src || (!stall && !deliver);

    // Fetch FSM and PC. A redirect that leaves a granted request unanswered
    // goes to DROP so the owed response is consumed and thrown away.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= FETCH_REQ;
            pc       <= RESET_PC;
            hold_buf <= NOP_INSTR;
        end else if (pc_src) begin
            pc       <= align_pc(branch_target);
            hold_buf <= NOP_INSTR;
            case (state)
                FETCH_REQ:  state <= imem_gnt    ? FETCH_DROP : FETCH_REQ;
                FETCH_WAIT: state <= imem_rvalid ? FETCH_REQ  : FETCH_DROP;
                FETCH_HOLD: state <= FETCH_REQ;
                FETCH_DROP: state <= imem_rvalid ? FETCH_REQ  : FETCH_DROP;
                default:    state <= FETCH_REQ;
            endcase
        end else begin
            case (state)
                FETCH_REQ: begin
                    if (imem_gnt) begin
                        state <= FETCH_WAIT;
                    end
                end
                FETCH_WAIT: begin
                    if (imem_rvalid) begin
                        if (stall) begin
                            hold_buf <= imem_rdata;
                            state    <= FETCH_HOLD;
                        end else begin
                            pc    <= pc_plus4;
                            state <= FETCH_REQ;
                        end
                    end
                end
                FETCH_HOLD: begin
                    if (!stall) begin
                        pc       <= pc_plus4;
                        hold_buf <= NOP_INSTR;
                        state    <= FETCH_REQ;
                    end
                end
                FETCH_DROP: begin
                    if (imem_rvalid) begin
                        state <= FETCH_REQ;
                    end
                end
                default: state <= FETCH_REQ;
            endcase
        end
    end

    if_id_reg #(
        .BUBBLE_INSTR(NOP_INSTR)
    ) u_if_id_reg (
        .clock       (clock),
        .reset       (reset),
        .load        (if_id_load),
        .bubble      (if_id_bubble),
        .instr_in    (deliver_instr),
        .npc_in      (pc_plus4),
        .instruction (if_id_instruction_out),
        .npc         (if_id_npc_out),
        .valid       (if_id_valid)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch
// Self-checking bench for instruction_fetch. A small memory responder serves
// the fetch port; a transaction-level model (fetch pointer, one outstanding
// request with a "stale" flag, a one-deep held-instruction queue) predicts
// the outputs every cycle. Directed scenarios pin the model with literal
// values, then a randomized run exercises stalls, redirects and latencies.
// A second instance with RESET_PC = FFFF_FFFC checks PC wrap-around.
// ---------------------------------------------------------------------------
module tb_instruction_fetch;

    import instruction_fetch_pkg::*;

    localparam logic [31:0] HI_RESET_PC = 32'hFFFF_FFFC;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        pc_src = 1'b0;
    logic [31:0] branch_target = '0;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] if_id_instruction_out;
    logic [31:0] if_id_npc_out;
    logic        if_id_valid;

    logic        hi_req;
    logic [31:0] hi_addr;
    logic [31:0] hi_instr;
    logic [31:0] hi_npc;
    logic        hi_valid;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] m_pc;
    bit          m_outstanding;
    bit          m_stale;
    logic [31:0] m_held[$];
    logic [31:0] exp_instr;
    logic [31:0] exp_npc;
    bit          exp_valid;

    // Memory responder state
    bit          mem_busy;
    int          mem_wait;
    logic [31:0] mem_addr;
    int          mem_lat = 1;
    bit          random_lat = 1'b0;
    bit          inject_rvalid = 1'b0;
    bit          dut_req_q;
    logic [31:0] dut_addr_q;

    always #5 clock = ~clock;

    instruction_fetch dut (
        .clock                 (clock),
        .reset                 (reset),
        .stall                 (stall),
        .pc_src                (pc_src),
        .branch_target         (branch_target),
        .imem_req              (imem_req),
        .imem_addr             (imem_addr),
        .imem_gnt              (imem_gnt),
        .imem_rvalid           (imem_rvalid),
        .imem_rdata            (imem_rdata),
        .if_id_instruction_out (if_id_instruction_out),
        .if_id_npc_out         (if_id_npc_out),
        .if_id_valid           (if_id_valid)
    );

    instruction_fetch #(
        .RESET_PC(HI_RESET_PC)
    ) dut_hi (
        .clock                 (clock),
        .reset                 (reset),
        .stall                 (stall),
        .pc_src                (pc_src),
        .branch_target         (branch_target),
        .imem_req              (hi_req),
        .imem_addr             (hi_addr),
        .imem_gnt              (imem_gnt),
        .imem_rvalid           (imem_rvalid),
        .imem_rdata            (imem_rdata),
        .if_id_instruction_out (hi_instr),
        .if_id_npc_out         (hi_npc),
        .if_id_valid           (hi_valid)
    );

    // Instruction memory contents: two real instructions, the rest a pattern.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr == 32'h0) return 32'h0050_0093;
        if (addr == 32'h4) return 32'h00A0_0113;
        return addr ^ 32'h1357_9BDF;
    endfunction

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_pc          = DEFAULT_RESET_PC;
        m_outstanding = 1'b0;
        m_stale       = 1'b0;
        m_held.delete();
        exp_instr     = NOP_INSTR;
        exp_npc       = '0;
        exp_valid     = 1'b0;
        mem_busy      = 1'b0;
        mem_wait      = 0;
        mem_addr      = '0;
    endtask

    // One clock edge of the transaction model, using the inputs in force.
    task automatic modelStep();
        bit          m_req;
        bit          got;
        bit          have;
        logic [31:0] word;
        m_req = !m_outstanding && (m_held.size() == 0);
        got   = m_outstanding && imem_rvalid;
        have  = 1'b0;
        word  = '0;
        if (pc_src) begin
            m_held.delete();
            if (m_req && imem_gnt) begin
                m_outstanding = 1'b1;
                m_stale       = 1'b1;
            end else if (got) begin
                m_outstanding = 1'b0;
            end else if (m_outstanding) begin
                m_stale = 1'b1;
            end
            m_pc      = {branch_target[31:2], 2'b00};
            exp_instr = NOP_INSTR;
            exp_npc   = '0;
            exp_valid = 1'b0;
        end else begin
            if (m_req && imem_gnt) begin
                m_outstanding = 1'b1;
                m_stale       = 1'b0;
            end else if (got) begin
                m_outstanding = 1'b0;
                if (!m_stale) begin
                    if (stall) begin
                        m_held.push_back(mem_word(m_pc));
                    end else begin
                        have = 1'b1;
                        word = mem_word(m_pc);
                    end
                end
            end else if (m_held.size() != 0 && !stall) begin
                have = 1'b1;
                word = m_held.pop_front();
            end
            if (!stall) begin
                if (have) begin
                    exp_instr = word;
                    exp_npc   = m_pc + 32'd4;
                    exp_valid = 1'b1;
                    m_pc      = m_pc + 32'd4;
                end else begin
                    exp_instr = NOP_INSTR;
                    exp_npc   = '0;
                    exp_valid = 1'b0;
                end
            end
        end
    endtask

    // Memory responder bookkeeping for the same edge.
    task automatic memStep();
        if (imem_rvalid && !inject_rvalid) mem_busy = 1'b0;
        if (dut_req_q && imem_gnt) begin
            mem_busy = 1'b1;
            mem_addr = dut_addr_q;
            mem_wait = mem_lat - 1;
        end else if (mem_busy && mem_wait > 0) begin
            mem_wait--;
        end
    endtask

    task automatic applyStimulus(input bit g, input bit s, input bit p, input logic [31:0] t);
        dut_req_q     = imem_req;
        dut_addr_q    = imem_addr;
        imem_gnt      = g;
        stall         = s;
        pc_src        = p;
        branch_target = t;
        if (random_lat) mem_lat = $urandom_range(1, 3);
        if (inject_rvalid) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
        end else if (mem_busy && mem_wait == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mem_addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
    endtask

    task automatic checkOutput();
        checkValue("imem_req", imem_req, !m_outstanding && (m_held.size() == 0));
        checkValue("imem_addr", imem_addr, m_pc);
        checkValue("if_id_instr", if_id_instruction_out, exp_instr);
        checkValue("if_id_npc", if_id_npc_out, exp_npc);
        checkValue("if_id_valid", if_id_valid, exp_valid);
    endtask

    task automatic cycle(input bit g, input bit s, input bit p, input logic [31:0] t);
        applyStimulus(g, s, p, t);
        @(posedge clock);
        modelStep();
        memStep();
        #1;
        checkOutput();
    endtask

    task automatic resetDut();
        reset         = 1'b0;
        imem_gnt      = 1'b0;
        stall         = 1'b0;
        pc_src        = 1'b0;
        imem_rvalid   = 1'b0;
        inject_rvalid = 1'b0;
        modelReset();
        @(posedge clock);
        #1;
        checkValue("rst_req", imem_req, 1'b0);
        checkValue("rst_instr", if_id_instruction_out, 32'h0000_0013);
        checkValue("rst_npc", if_id_npc_out, 32'h0);
        checkValue("rst_valid", if_id_valid, 1'b0);
        reset = 1'b1;
        #1;
    endtask

    initial begin
        resetDut();
        checkValue("rel_req", imem_req, 1'b1);
        checkValue("rel_addr", imem_addr, 32'h0);
        checkValue("hi_rel_addr", hi_addr, 32'hFFFF_FFFC);

        // Free run with 1-cycle memory
        cycle(1, 0, 0, 0);
        checkValue("wait_req", imem_req, 1'b0);
        cycle(0, 0, 0, 0);
        checkValue("f0_instr", if_id_instruction_out, 32'h0050_0093);
        checkValue("f0_npc", if_id_npc_out, 32'h4);
        checkValue("f0_valid", if_id_valid, 1'b1);
        checkValue("f1_addr", imem_addr, 32'h4);
        checkValue("hi_npc_wrap", hi_npc, 32'h0);
        checkValue("hi_valid", hi_valid, 1'b1);
        checkValue("hi_addr_wrap", hi_addr, 32'h0);
        checkValue("hi_req", hi_req, 1'b1);
        cycle(1, 0, 0, 0);
        checkValue("bubble_valid", if_id_valid, 1'b0);
        checkValue("bubble_instr", if_id_instruction_out, 32'h0000_0013);
        cycle(0, 0, 0, 0);
        checkValue("f1_instr", if_id_instruction_out, 32'h00A0_0113);
        checkValue("f1_npc", if_id_npc_out, 32'h8);
        checkValue("f2_addr", imem_addr, 32'h8);

        // Stall while the response for pc=8 arrives
        cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0);
        checkValue("hold_req0", imem_req, 1'b0);
        cycle(1, 1, 0, 0);
        checkValue("hold_req1", imem_req, 1'b0);
        cycle(1, 1, 0, 0);
        checkValue("hold_req2", imem_req, 1'b0);
        checkValue("hold_frozen", if_id_valid, 1'b0);
        cycle(1, 0, 0, 0);
        checkValue("hold_instr", if_id_instruction_out, 32'h1357_9BD7);
        checkValue("hold_npc", if_id_npc_out, 32'hC);
        checkValue("hold_valid", if_id_valid, 1'b1);
        checkValue("hold_next_addr", imem_addr, 32'hC);
        checkValue("hold_next_req", imem_req, 1'b1);

        // Redirect while waiting on pc=16
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        checkValue("f3_instr", if_id_instruction_out, 32'h1357_9BD3);
        checkValue("f4_addr", imem_addr, 32'h10);
        mem_lat = 2;
        cycle(1, 0, 0, 0);
        cycle(0, 0, 1, 32'h0000_0102);
        checkValue("redir_bubble", if_id_valid, 1'b0);
        checkValue("drop_req", imem_req, 1'b0);
        checkValue("redir_pc", imem_addr, 32'h100);
        mem_lat = 1;
        cycle(0, 0, 0, 0);
        checkValue("drop_discard", if_id_valid, 1'b0);
        checkValue("after_drop_req", imem_req, 1'b1);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        checkValue("tgt_instr", if_id_instruction_out, 32'h1357_9ADF);
        checkValue("tgt_npc", if_id_npc_out, 32'h104);
        checkValue("tgt_valid", if_id_valid, 1'b1);

        // Redirect and stall together while HOLD has data
        cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0);
        checkValue("hold2_req", imem_req, 1'b0);
        cycle(0, 1, 1, 32'h0000_0200);
        checkValue("flush_valid", if_id_valid, 1'b0);
        checkValue("flush_instr", if_id_instruction_out, 32'h0000_0013);
        checkValue("flush_addr", imem_addr, 32'h200);
        checkValue("flush_req", imem_req, 1'b1);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        checkValue("flush_next_instr", if_id_instruction_out, 32'h1357_99DF);
        checkValue("flush_next_npc", if_id_npc_out, 32'h204);

        // Reset in the middle of WAIT, then a stale response
        mem_lat = 3;
        cycle(1, 0, 0, 0);
        resetDut();
        inject_rvalid = 1'b1;
        cycle(0, 0, 0, 0);
        inject_rvalid = 1'b0;
        checkValue("stale_instr", if_id_instruction_out, 32'h0000_0013);
        checkValue("stale_npc", if_id_npc_out, 32'h0);
        checkValue("stale_valid", if_id_valid, 1'b0);
        checkValue("stale_req", imem_req, 1'b1);
        checkValue("stale_addr", imem_addr, 32'h0);
        mem_lat = 1;

        // Randomized run against the model
        random_lat = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tgt;
            tgt = $urandom;
            if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) == 0, tgt);
            if (i == 1500) resetDut();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
